conta_btn_cond: RTL and testbench

Button conditioner that sits directly upstream of the 3-bit counter and drives its up/down step inputs. It synchronises two raw push-button inputs, debounces them, and emits single-cycle step pulses with hold-to-auto-repeat. The counter consumes up_pulse/dn_pulse as count-enable strobes, and the block guarantees the two are never high in the same cycle.

---
 rtl/conta_btn_cond.sv | 225 ++++++++++++++++++++++
 tb/tb_conta_btn_cond.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conta_btn_cond.sv
// Push-button conditioner for the 3-bit counter: per-channel sync, debounce and
// hold-to-repeat, followed by registered up/down arbitration.

module conta_btn_chan #(
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned REPEAT_DELAY  = 16,
    parameter int unsigned REPEAT_PERIOD = 8,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic btn_raw,
    output logic level,
    output logic raw_pulse
);

    // state   | meaning
    // IDLE    | button released or ena low, no pulses pending
    // DELAY   | press pulse sent, waiting REPEAT_DELAY cycles for first repeat
    // REPEAT  | held, one pulse every REPEAT_PERIOD cycles
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_TC  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_TC = CNT_W'(REPEAT_PERIOD);

    logic             s1_q;
    logic             s2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] deb_cnt_q;
    logic [CNT_W-1:0] deb_cnt_d;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] rep_cnt_q;
    logic [CNT_W-1:0] rep_cnt_d;
    logic             pulse_d;
    logic             level_rise;
    logic             level_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
        end
    end

    // Counter only runs while the synchronised input disagrees with the level,
    // so any agreeing cycle restarts the qualification window.
    always_comb begin
        level_d   = level_q;
        deb_cnt_d = '0;
        if (s2_q != level_q) begin
            if (deb_cnt_q >= DEB_LAST) begin
                level_d = ~level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q   <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign level_rise = level_d & ~level_q;
    assign level_fall = ~level_d & level_q;

    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        pulse_d   = 1'b0;
        if (!ena) begin
            state_d   = ST_IDLE;
            rep_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    rep_cnt_d = '0;
                    if (level_rise) begin
                        state_d   = ST_DELAY;
                        rep_cnt_d = CNT_ONE;
                        pulse_d   = 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (level_fall) begin
                        state_d   = ST_IDLE;
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q >= DELAY_TC) begin
                        state_d   = ST_REPEAT;
                        rep_cnt_d = CNT_ONE;
                        pulse_d   = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (level_fall) begin
                        state_d   = ST_IDLE;
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q >= PERIOD_TC) begin
                        rep_cnt_d = CNT_ONE;
                        pulse_d   = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    rep_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    assign level     = level_q;
    assign raw_pulse = pulse_d;

endmodule

module conta_btn_cond #(
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned REPEAT_DELAY  = 16,
    parameter int unsigned REPEAT_PERIOD = 8,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic btn_up_raw,
    input  logic btn_dn_raw,
    output logic up_pulse,
    output logic dn_pulse,
    output logic up_level,
    output logic dn_level,
    output logic conflict
);

    logic raw_up;
    logic raw_dn;
    logic up_pulse_q;
    logic up_pulse_d;
    logic dn_pulse_q;
    logic dn_pulse_d;
    logic conflict_q;
    logic conflict_d;

    conta_btn_chan #(
        .DEB_CYCLES    (DEB_CYCLES),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .CNT_W         (CNT_W)
    ) u_chan_up (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .btn_raw   (btn_up_raw),
        .level     (up_level),
        .raw_pulse (raw_up)
    );

    conta_btn_chan #(
        .DEB_CYCLES    (DEB_CYCLES),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .CNT_W         (CNT_W)
    ) u_chan_dn (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .btn_raw   (btn_dn_raw),
        .level     (dn_level),
        .raw_pulse (raw_dn)
    );

    // Simultaneous requests cancel: the counter must never see both enables.
    always_comb begin
        up_pulse_d = raw_up & ~raw_dn;
        dn_pulse_d = raw_dn & ~raw_up;
        conflict_d = raw_up & raw_dn;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_pulse_q <= 1'b0;
            dn_pulse_q <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            up_pulse_q <= up_pulse_d;
            dn_pulse_q <= dn_pulse_d;
            conflict_q <= conflict_d;
        end
    end

    assign up_pulse = up_pulse_q;
    assign dn_pulse = dn_pulse_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_conta_btn_cond.sv
// Directed bench for conta_btn_cond: expected pulse events are queued as each
// stimulus step is driven and compared against the events the DUT emits.

module tb_conta_btn_cond;

    logic clk;
    logic rst;
    logic ena;
    logic btn_up_raw;
    logic btn_dn_raw;
    logic up_pulse;
    logic dn_pulse;
    logic up_level;
    logic dn_level;
    logic conflict;

    typedef struct packed {
        int   cyc;
        logic up;
        logic dn;
        logic cf;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc;
    int  checks;
    int  errors;
    int  n;
    int  t;

    conta_btn_cond dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .btn_up_raw (btn_up_raw),
        .btn_dn_raw (btn_dn_raw),
        .up_pulse   (up_pulse),
        .dn_pulse   (dn_pulse),
        .up_level   (up_level),
        .dn_level   (dn_level),
        .conflict   (conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event capture plus the never-both-pulses invariant, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (!(up_pulse === 1'b1 && dn_pulse === 1'b1)) else begin
                errors++;
                $error("FAIL both_pulses cyc %0d: observed up=%b dn=%b expected not both 1",
                       cyc, up_pulse, dn_pulse);
            end
            if (up_pulse !== 1'b0 || dn_pulse !== 1'b0 || conflict !== 1'b0)
                obs_q.push_back(mk(cyc, up_pulse, dn_pulse, conflict));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic ev_t mk(input int c, input logic u, input logic d, input logic f);
        ev_t e;
        e.cyc = c;
        e.up  = u;
        e.dn  = d;
        e.cf  = f;
        return e;
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_events(input string tag);
        ev_t e;
        ev_t o;
        checks++;
        assert (obs_q.size() === exp_q.size()) else begin
            errors++;
            $error("FAIL %s count: observed %0d expected %0d", tag, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL %s event: observed cyc=%0d up=%b dn=%b cf=%b expected cyc=%0d up=%b dn=%b cf=%b",
                       tag, o.cyc, o.up, o.dn, o.cf, e.cyc, e.up, e.dn, e.cf);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    function automatic logic [4:0] outs();
        return {up_pulse, dn_pulse, conflict, up_level, dn_level};
    endfunction

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        ena        = 1'b1;
        btn_up_raw = 1'b0;
        btn_dn_raw = 1'b0;

        // Reset asserted mid-cycle, then 20 idle cycles
        #2 rst = 1'b1;
        #1 chk("reset_async", outs(), 5'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = cyc;
        wait_until(n + 20);
        chk("idle_outs", outs(), 5'b0);
        check_events("idle");

        // Single press held 10 cycles
        @(negedge clk);
        btn_up_raw = 1'b1;
        n = cyc + 1;
        exp_q.push_back(mk(n + 5, 1'b1, 1'b0, 1'b0));
        wait_until(n + 4);
        chk("press_lvl_pre", {4'b0, up_level}, 5'd0);
        wait_until(n + 5);
        chk("press_lvl_rise", {4'b0, up_level}, 5'd1);
        wait_until(n + 9);
        btn_up_raw = 1'b0;
        wait_until(n + 14);
        chk("release_lvl_pre", {4'b0, up_level}, 5'd1);
        wait_until(n + 15);
        chk("release_lvl_fall", {4'b0, up_level}, 5'd0);
        wait_until(n + 20);
        check_events("single_press");

        // 3-cycle glitch rejected
        @(negedge clk);
        btn_dn_raw = 1'b1;
        n = cyc + 1;
        wait_until(n + 2);
        btn_dn_raw = 1'b0;
        wait_until(n + 5);
        chk("glitch3_lvl", {4'b0, dn_level}, 5'd0);
        wait_until(n + 12);
        check_events("glitch3");

        // 4-cycle glitch accepted
        @(negedge clk);
        btn_dn_raw = 1'b1;
        n = cyc + 1;
        exp_q.push_back(mk(n + 5, 1'b0, 1'b1, 1'b0));
        wait_until(n + 3);
        btn_dn_raw = 1'b0;
        wait_until(n + 5);
        chk("glitch4_lvl", {4'b0, dn_level}, 5'd1);
        wait_until(n + 15);
        chk("glitch4_lvl_end", {4'b0, dn_level}, 5'd0);
        check_events("glitch4");

        // Auto-repeat: 60-cycle hold, level falls at n+65
        @(negedge clk);
        btn_up_raw = 1'b1;
        n = cyc + 1;
        exp_q.push_back(mk(n + 5, 1'b1, 1'b0, 1'b0));
        for (t = n + 21; t < n + 65; t += 8) exp_q.push_back(mk(t, 1'b1, 1'b0, 1'b0));
        wait_until(n + 59);
        btn_up_raw = 1'b0;
        wait_until(n + 80);
        check_events("auto_repeat");

        // Simultaneous press: every pulse collides
        @(negedge clk);
        btn_up_raw = 1'b1;
        btn_dn_raw = 1'b1;
        n = cyc + 1;
        exp_q.push_back(mk(n + 5, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(n + 21, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(n + 29, 1'b0, 1'b0, 1'b1));
        wait_until(n + 5);
        chk("both_levels", {3'b0, up_level, dn_level}, 5'b00011);
        wait_until(n + 29);
        btn_up_raw = 1'b0;
        btn_dn_raw = 1'b0;
        wait_until(n + 45);
        check_events("collision");

        // Staggered by 3 cycles: interleaved, separate pulses
        @(negedge clk);
        btn_up_raw = 1'b1;
        n = cyc + 1;
        exp_q.push_back(mk(n + 5, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(n + 8, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(n + 21, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(n + 24, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(n + 29, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(n + 32, 1'b0, 1'b1, 1'b0));
        wait_until(n + 2);
        btn_dn_raw = 1'b1;
        wait_until(n + 29);
        btn_up_raw = 1'b0;
        wait_until(n + 32);
        btn_dn_raw = 1'b0;
        wait_until(n + 50);
        check_events("stagger");

        // ena low while pressed, then raised while still held
        @(negedge clk);
        ena = 1'b0;
        btn_up_raw = 1'b1;
        n = cyc + 1;
        wait_until(n + 5);
        chk("ena0_lvl", {4'b0, up_level}, 5'd1);
        wait_until(n + 30);
        ena = 1'b1;
        wait_until(n + 60);
        chk("ena1_lvl", {4'b0, up_level}, 5'd1);
        btn_up_raw = 1'b0;
        wait_until(n + 75);
        check_events("ena_hold");

        // Reset during REPEAT with button held, then restart
        @(negedge clk);
        btn_up_raw = 1'b1;
        n = cyc + 1;
        exp_q.push_back(mk(n + 5, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(n + 21, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(n + 29, 1'b1, 1'b0, 1'b0));
        wait_until(n + 29);
        chk("pre_rst_outs", outs(), 5'b10010);
        #1 rst = 1'b1;
        #1 chk("mid_hold_rst", outs(), 5'b0);
        wait_until(n + 31);
        rst = 1'b0;
        exp_q.push_back(mk(n + 37, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(n + 53, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(n + 61, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(n + 69, 1'b1, 1'b0, 1'b0));
        wait_until(n + 36);
        chk("post_rst_lvl_pre", {4'b0, up_level}, 5'd0);
        wait_until(n + 37);
        chk("post_rst_lvl", {4'b0, up_level}, 5'd1);
        wait_until(n + 70);
        btn_up_raw = 1'b0;
        wait_until(n + 90);
        check_events("rst_mid_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
